// File: rtl/multiword_add_sequencer.sv
// Multi-cycle adder/subtractor. A WIDTH-bit add or subtract is split into
// SLICE-bit chunks. One chunk is processed per cycle, starting with the LSB
// slice, and the carry is rippled through a register between chunks.
// Requests and results use valid/ready handshakes.

// One SLICE-bit adder with carry-in and carry-out.
module mws_slice_add #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             ci,
    output logic [SLICE-1:0] s,
    output logic             co
);
    assign {co, s} = (SLICE+1)'(a) + (SLICE+1)'(b) + (SLICE+1)'(ci);
endmodule

module multiword_add_sequencer #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);
    localparam int NSLICES = WIDTH / SLICE;
    localparam int IDXW    = (NSLICES > 1) ? $clog2(NSLICES) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NSLICES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state_q, state_d;
    logic [NSLICES-1:0][SLICE-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic carry_q, carry_d, c_out_q, c_out_d, ovf_q, ovf_d;
    logic [SLICE-1:0] slice_s;
    logic             slice_cy;

    // Shared slice adder. It works on the slice selected by idx_q.
    mws_slice_add #(.SLICE(SLICE)) u_slice (
        .a  (a_q[idx_q]),
        .b  (b_q[idx_q]),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_cy)
    );

    // State register. Reset abandons any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic. RUN lasts exactly NSLICES cycles.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)        state_d = RUN;
            RUN:     if (idx_q == LAST)   state_d = DONE;
            DONE:    if (out_ready)       state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    // Handshake outputs, decoded from the state.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Datapath registers. Results persist after DONE until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    // Datapath next values. Subtraction is done as a + ~b + 1, with the +1
    // supplied as the initial carry.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = a;
                b_d     = sub ? ~b : b;
                carry_d = sub ? 1'b1 : c_in;
                idx_d   = '0;
                sum_d   = '0;
            end
            RUN: begin
                sum_d[idx_q] = slice_s;
                carry_d      = slice_cy;
                idx_d        = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    idx_d   = '0;
                    c_out_d = slice_cy;
                    // The sign of the result comes from the top bit of the final slice.
                    ovf_d   = (a_q[NSLICES-1][SLICE-1] == b_q[NSLICES-1][SLICE-1]) &&
                              (slice_s[SLICE-1] != a_q[NSLICES-1][SLICE-1]);
                end
            end
            default: ;
        endcase
    end

    assign sum      = sum_q;
    assign c_out    = c_out_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed bench for multiword_add_sequencer with default parameters
// (WIDTH=16, SLICE=4, so 4 slices and a latency of 4 edges).
module tb_multiword_add_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        c_in = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] sum;
    logic        c_out;
    logic        overflow;

    int nvec = 0;
    int nerr = 0;

    multiword_add_sequencer #(.WIDTH(16), .SLICE(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one request. After acceptance the inputs are scrambled so the
    // in-flight result must come from the latched values. The task checks
    // latency and results. If out_ready is high, it also checks the return
    // to IDLE.
    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                          input logic tc, input logic ts,
                          input logic [15:0] es, input logic ec, input logic eo);
        int edges;
        @(negedge clk);
        a = ta; b = tb; c_in = tc; sub = ts; in_valid = 1'b1;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; a = ~ta; b = ~tb; c_in = ~tc; sub = ~ts;
        edges = 0;
        while (!out_valid && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        chk({tag, ".latency"}, 32'(edges), 32'd4);
        chk({tag, ".sum"},      32'(sum),      32'(es));
        chk({tag, ".c_out"},    32'(c_out),    32'(ec));
        chk({tag, ".overflow"}, 32'(overflow), 32'(eo));
        if (out_ready) begin
            @(posedge clk); #1;
            chk({tag, ".idle"}, {30'd0, out_valid, in_ready}, 32'b01);
        end
    endtask

    initial begin
        // Reset state, checked with no clock edge involved.
        #2;
        chk("rst.in_ready",  32'(in_ready),  32'd1);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.sum",       32'(sum),       32'd0);
        chk("rst.c_out",     32'(c_out),     32'd0);
        chk("rst.overflow",  32'(overflow),  32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Directed arithmetic vectors.
        run_op("add4_5",    16'h0004, 16'h0005, 1'b0, 1'b0, 16'h0009, 1'b0, 1'b0);
        run_op("ripple",    16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("sub5_7",    16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub7_5",    16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
        run_op("ovf_pos",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("ovf_neg",   16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        run_op("mixed",     16'h1234, 16'h0FCD, 1'b1, 1'b0, 16'h2202, 1'b0, 1'b0);

        // Back-pressure: hold DONE while offering a new request.
        out_ready = 1'b0;
        run_op("bp",        16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = 16'hDEAD + 16'(i); b = 16'hBEEF; in_valid = 1'b1;
            @(posedge clk); #1;
            chk("bp.sum",       32'(sum),       32'h2345);
            chk("bp.out_valid", 32'(out_valid), 32'd1);
            chk("bp.in_ready",  32'(in_ready),  32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp.release", {30'd0, out_valid, in_ready}, 32'b01);
        chk("bp.retain",  32'(sum), 32'h2345);
        @(posedge clk); #1;
        chk("bp.no_accept", 32'(in_ready), 32'd1);

        // Reset asserted mid-RUN (idx=2) abandons the operation.
        @(negedge clk);
        a = 16'hAAAA; b = 16'h5555; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid.partial", 32'(sum), 32'h00FF);
        @(negedge clk);
        rst_n = 1'b0; #1;
        chk("mid.sum",       32'(sum),       32'd0);
        chk("mid.c_out",     32'(c_out),     32'd0);
        chk("mid.overflow",  32'(overflow),  32'd0);
        chk("mid.in_ready",  32'(in_ready),  32'd1);
        chk("mid.out_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("mid.hold_valid", 32'(out_valid), 32'd0);
        end
        @(negedge clk); rst_n = 1'b1;
        run_op("post_rst",  16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/multiword_add_sequencer.md
MULTIWORD_ADD_SEQUENCER -- requirements
Module: multiword_add_sequencer

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result width in bits.
REQ-002 Parameter: SLICE, default 4, adder slice width in bits; WIDTH SHALL be an integer multiple of SLICE, SLICE >= 1; NSLICES = WIDTH/SLICE.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  request present on a, b, c_in, sub.
REQ-006 in_ready  output  1  block accepts a request this cycle.
REQ-007 a  input  WIDTH  operand A, unsigned or two's complement.
REQ-008 b  input  WIDTH  operand B.
REQ-009 c_in  input  1  carry-in for add; ignored when sub=1.
REQ-010 sub  input  1  0: a+b+c_in; 1: a-b, computed as a+~b+1.
REQ-011 out_valid  output  1  result present on sum, c_out, overflow.
REQ-012 out_ready  input  1  consumer takes result this cycle.
REQ-013 sum  output  WIDTH  registered result.
REQ-014 c_out  output  1  registered carry out of the MSB slice.
REQ-015 overflow  output  1  registered two's-complement overflow flag.

Function
REQ-016 FSM states SHALL be IDLE, RUN, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-017 IDLE: on in_valid=1 (handshake), latch a, b' = sub ? ~b : b, carry register = sub ? 1 : c_in, slice index = 0, clear sum register, go RUN; otherwise stay.
REQ-018 RUN: each cycle one SLICE-bit add SHALL be performed: {cy, s} = a[idx slice] + b'[idx slice] + carry; write s into sum[idx slice], carry <= cy, idx <= idx+1.
REQ-019 Slice order SHALL be LSB slice first (idx 0 = bits SLICE-1:0).
REQ-020 RUN SHALL last exactly NSLICES cycles; on the cycle processing idx = NSLICES-1, go DONE and register c_out = cy and overflow.
REQ-021 overflow SHALL equal (a[MSB] == b'[MSB]) && (final sum[MSB] != a[MSB]).
REQ-022 Latency: out_valid SHALL rise exactly NSLICES+1 rising edges after the accepting edge's cycle start, i.e. at the NSLICES-th edge after the accepting edge, (4 edges for defaults).
REQ-023 DONE: sum, c_out, overflow SHALL be held stable while out_ready=0; on out_ready=1 go IDLE.
REQ-024 No request SHALL be accepted in RUN or DONE; in_valid there is ignored, operands not sampled.
REQ-025 Minimum request spacing: NSLICES+2 cycles (accept, NSLICES RUN, DONE with out_ready=1).
REQ-026 After leaving DONE, sum/c_out/overflow SHALL retain last result until the next acceptance clears sum.
REQ-027 Input changes on a, b, c_in, sub after acceptance SHALL NOT affect the in-flight result.
REQ-028 Arithmetic wraps modulo 2^WIDTH; carry beyond MSB appears only on c_out.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE, idx 0, carry 0, sum 0, c_out 0, overflow 0, out_valid 0, in_ready 1, independent of clk.
REQ-030 Reset during RUN or DONE SHALL abandon the operation with no out_valid pulse; first edge after rst_n rises may accept a new request.

Verification
REQ-031 a=4, b=5, c_in=0, sub=0, out_ready=1 -> out_valid 4 edges after accept, sum=9, c_out=0, overflow=0.
REQ-032 a=0xFFFF, b=0x0000, c_in=1 -> sum=0x0000, c_out=1, overflow=0 (carry ripples through all 4 slices).
REQ-033 sub=1, a=5, b=7, c_in=1 (ignored) -> sum=0xFFFE, c_out=0; sub=1, a=7, b=5 -> sum=0x0002, c_out=1.
REQ-034 a=0x7FFF, b=0x0001, c_in=0 -> sum=0x8000, overflow=1, c_out=0; a=0x8000, b=0x8000 -> sum=0, overflow=1, c_out=1.
REQ-035 out_ready held 0 for 3 cycles in DONE, a/b changed and in_valid=1 meanwhile -> outputs stable, in_ready=0, no second acceptance; out_ready=1 -> IDLE next cycle.
REQ-036 rst_n pulsed low mid-RUN (idx=2) -> all outputs 0 asynchronously, in_ready=1, no out_valid; following request a=1, b=2 -> sum=3.
